pe_seq_pv1: RTL and testbench

Hardware sequencer for the pv1 processing element: it drives the PE's local-RAM load port and MAC issue port, replacing the hand-written stimulus sequence used in bench bring-up. It accepts two 8-bit streams over valid/ready handshakes:

- **din:** weights written into PE RAM.
- **ain:** activations issued against those weights.

After the last MAC it waits a fixed pipeline drain, then captures the PE's 48-bit accumulator and holds it as a result until the consumer accepts it. It sits between the host/DMA side and one `my_pe_pv1` instance.

---
 rtl/pe_seq_pv1.sv | 165 ++++++++++++++++
 tb/tb_pe_seq_pv1.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_pv1.sv
// pe_seq_pv1: sequencer for one pv1 processing element.
// Loads N weights into PE RAM, clears the accumulator, issues N MACs, waits for the
// PE pipeline to drain, then captures the accumulator and holds it until accepted.
module pe_seq_pv1 #(
    parameter int unsigned L_RAM_SIZE = 4,
    parameter int unsigned PE_LAT     = 4,
    parameter int unsigned ACC_W      = 48
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [L_RAM_SIZE-1:0] len_m1,
    input  logic                  sub,
    input  logic [7:0]            d_data,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [7:0]            a_data,
    input  logic                  a_valid,
    output logic                  a_ready,
    output logic [L_RAM_SIZE-1:0] pe_addr,
    output logic                  pe_we,
    output logic [7:0]            pe_din,
    output logic [7:0]            pe_ain,
    output logic                  pe_valid,
    output logic                  pe_subtract,
    output logic                  pe_clear,
    input  logic [ACC_W-1:0]      pe_pcout,
    output logic                  busy,
    output logic [ACC_W-1:0]      res_data,
    output logic                  res_valid,
    input  logic                  res_ready
);

    localparam int unsigned DrainW = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StClear   = 3'd2,
        StCompute = 3'd3,
        StDrain   = 3'd4,
        StDone    = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [L_RAM_SIZE-1:0] k_q, k_d;
    logic [L_RAM_SIZE-1:0] len_q, len_d;
    logic                  sub_q, sub_d;
    logic [DrainW-1:0]     drain_q, drain_d;
    logic                  d_beat, a_beat, last_k, drain_done;

    // Ready decodes the current state only, so a beat is never taken outside its phase.
    assign d_ready    = (state_q == StLoad);
    assign a_ready    = (state_q == StCompute);
    assign d_beat     = d_valid & d_ready;
    assign a_beat     = a_valid & a_ready;
    assign last_k     = (k_q == len_q);
    assign drain_done = (state_q == StDrain) && (drain_q == '0);

    // Next-state logic for the sequencer FSM, beat counter and drain counter.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        sub_d   = sub_q;
        drain_d = drain_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = len_m1;
                    sub_d   = sub;
                    k_d     = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (d_beat) begin
                    if (last_k) state_d = StClear;
                    else        k_d     = k_q + L_RAM_SIZE'(1);
                end
            end
            StClear: begin
                k_d     = '0;
                state_d = StCompute;
            end
            StCompute: begin
                if (a_beat) begin
                    if (last_k) begin
                        state_d = StDrain;
                        drain_d = DrainW'(PE_LAT);
                    end else begin
                        k_d = k_q + L_RAM_SIZE'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_q == '0) state_d = StDone;
                else               drain_d = drain_q - DrainW'(1);
            end
            StDone: begin
                if (res_valid && res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
            k_q     <= '0;
            len_q   <= '0;
            sub_q   <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            len_q   <= len_d;
            sub_q   <= sub_d;
            drain_q <= drain_d;
        end
    end

    // Registered PE-side outputs; write and MAC beats never coincide so they share pe_addr.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pe_addr     <= '0;
            pe_we       <= 1'b0;
            pe_din      <= '0;
            pe_ain      <= '0;
            pe_valid    <= 1'b0;
            pe_subtract <= 1'b0;
            pe_clear    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pe_we       <= d_beat;
            pe_valid    <= a_beat;
            pe_clear    <= (state_q == StClear);
            pe_subtract <= (state_d != StIdle) & sub_d;
            busy        <= (state_d != StIdle);
            if (d_beat) begin
                pe_din  <= d_data;
                pe_addr <= k_q;
            end
            if (a_beat) begin
                pe_ain  <= a_data;
                pe_addr <= k_q;
            end
        end
    end

    // Result capture at the end of the drain; held until the consumer takes it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            res_data  <= '0;
            res_valid <= 1'b0;
        end else if (drain_done) begin
            res_data  <= pe_pcout;
            res_valid <= 1'b1;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_seq_pv1.sv
// Bench for pe_seq_pv1: behavioural PE model, table of operations, scoreboard of results.
module tb_pe_seq_pv1;

    localparam int PE_LAT = 4;

    logic        aclk = 1'b0;
    logic        areset, start, sub;
    logic [3:0]  len_m1;
    logic [7:0]  d_data, a_data;
    logic        d_valid, d_ready, a_valid, a_ready;
    logic [3:0]  pe_addr;
    logic        pe_we, pe_valid, pe_subtract, pe_clear, busy;
    logic [7:0]  pe_din, pe_ain;
    logic [47:0] pe_pcout, res_data;
    logic        res_valid, res_ready;

    pe_seq_pv1 #(.L_RAM_SIZE(4), .PE_LAT(PE_LAT), .ACC_W(48)) dut (
        .aclk(aclk), .areset(areset), .start(start), .len_m1(len_m1), .sub(sub),
        .d_data(d_data), .d_valid(d_valid), .d_ready(d_ready),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .pe_addr(pe_addr), .pe_we(pe_we), .pe_din(pe_din), .pe_ain(pe_ain),
        .pe_valid(pe_valid), .pe_subtract(pe_subtract), .pe_clear(pe_clear),
        .pe_pcout(pe_pcout), .busy(busy),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    // Behavioural PE: RAM, accumulator, and an output pipeline so pe_pcout is final
    // exactly PE_LAT cycles after the last pe_valid cycle.
    logic [7:0]  ram [16];
    logic [47:0] acc = '0;
    logic [47:0] pipe [PE_LAT-1];
    logic [47:0] prod;
    assign prod     = {40'b0, ram[pe_addr]} * {40'b0, pe_ain};
    assign pe_pcout = pipe[PE_LAT-2];

    always @(posedge aclk) begin
        if (pe_we) ram[pe_addr] <= pe_din;
        if (pe_clear)      acc <= '0;
        else if (pe_valid) acc <= pe_subtract ? acc - prod : acc + prod;
        pipe[0] <= acc;
        for (int i = 1; i < PE_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end

    // Monitor of PE-side traffic, sampled just after each active edge.
    int we_addr[$], we_data[$], we_cyc[$];
    int va_addr[$], va_data[$], va_cyc[$];
    int clr_n, clr_cyc, sub_bad;
    bit cur_sub;

    always @(posedge aclk) begin
        #1;
        if (pe_we) begin
            we_addr.push_back(int'(pe_addr)); we_data.push_back(int'(pe_din));
            we_cyc.push_back(cyc);
        end
        if (pe_valid) begin
            va_addr.push_back(int'(pe_addr)); va_data.push_back(int'(pe_ain));
            va_cyc.push_back(cyc);
        end
        if (pe_clear) begin
            clr_n++;
            clr_cyc = cyc;
        end
        if (pe_subtract !== (busy & cur_sub)) sub_bad++;
    end

    logic [47:0] exp_q[$];

    typedef struct {
        int          n;
        bit          sub;
        bit          gaps;
        bit          poke;
        int          base;
        int          step;
        int          aval;
        int          hold;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [27:0] outs_vec();
        return {d_ready, a_ready, pe_addr, pe_we, pe_din, pe_ain, pe_valid,
                pe_subtract, pe_clear, busy, res_valid};
    endfunction

    function automatic void clear_mon();
        we_addr.delete(); we_data.delete(); we_cyc.delete();
        va_addr.delete(); va_data.delete(); va_cyc.delete();
        clr_n = 0; clr_cyc = 0; sub_bad = 0;
    endfunction

    // Offers n beats on one stream; in the activation phase junk weights are also offered.
    task automatic stream(input bit is_a, input int n, input bit gaps, input bit poke,
                          input int base, input int step, input int aval);
        int k = 0;
        int j = 0;
        int guard = 0;
        bit rdy;
        while (k < n && guard < 200) begin
            @(negedge aclk);
            guard++;
            d_valid = 1'b0; a_valid = 1'b0; start = 1'b0;
            if (is_a) begin
                d_valid = 1'b1; d_data = 8'hEE;
            end
            rdy = is_a ? a_ready : d_ready;
            if (!is_a && guard == 1) check("d_ready_after_start", 64'(d_ready), 64'd1);
            if (rdy) begin
                if (poke && j == 0) begin
                    start = 1'b1; len_m1 = 4'd5; sub = 1'b1;
                end else if (!gaps || (j % 3) == 0) begin
                    if (is_a) begin a_valid = 1'b1; a_data = 8'(aval); end
                    else begin d_valid = 1'b1; d_data = 8'(base + k * step); end
                    k++;
                end
                j++;
            end
        end
        check(is_a ? "a_beats" : "d_beats", 64'(k), 64'(n));
    endtask

    task automatic run_op(input vec_t v);
        int          s, r;
        bit          tight;
        logic [47:0] want;
        tight = !v.gaps && !v.poke;
        @(negedge aclk);
        clear_mon();
        cur_sub   = v.sub;
        start     = 1'b1;
        len_m1    = 4'(v.n - 1);
        sub       = v.sub;
        res_ready = (v.hold == 0);
        s = cyc;
        exp_q.push_back(v.exp);
        stream(1'b0, v.n, v.gaps, 1'b0, v.base, v.step, v.aval);
        stream(1'b1, v.n, v.gaps, v.poke, v.base, v.step, v.aval);
        r = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            d_valid = 1'b0; a_valid = 1'b0; start = 1'b0;
            if (res_valid) begin
                r = cyc;
                break;
            end
        end
        check("res_valid_seen", 64'(res_valid), 64'd1);
        want = '0;
        if (res_valid && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("res_data", 64'(res_data), 64'(want));
            if (tight) check("start_to_res_valid", 64'(r - s), 64'(2 * v.n + PE_LAT + 3));
            if (va_cyc.size() > 0)
                check("last_valid_to_res_valid", 64'(r - va_cyc[$]), 64'(PE_LAT + 1));
        end else begin
            exp_q.delete();
        end
        for (int i = 0; i < v.hold; i++) begin
            if (i > 0) @(negedge aclk);
            check("hold_res_valid", 64'(res_valid), 64'd1);
            check("hold_res_data", 64'(res_data), 64'(want));
            check("hold_busy", 64'(busy), 64'd1);
        end
        if (v.hold > 0) begin
            @(negedge aclk);
            res_ready = 1'b1;
        end
        @(negedge aclk);
        check("res_valid_dropped", 64'(res_valid), 64'd0);
        check("idle_after_accept", 64'(busy), 64'd0);
        res_ready = 1'b0;

        check("we_count", 64'(we_addr.size()), 64'(v.n));
        check("valid_count", 64'(va_addr.size()), 64'(v.n));
        check("clear_count", 64'(clr_n), 64'd1);
        check("pe_subtract_track", 64'(sub_bad), 64'd0);
        if (we_addr.size() == v.n && va_addr.size() == v.n) begin
            for (int i = 0; i < v.n; i++) begin
                check("we_addr", 64'(we_addr[i]), 64'(i));
                check("we_data", 64'(we_data[i]), 64'(8'(v.base + i * v.step)));
                check("valid_addr", 64'(va_addr[i]), 64'(i));
                check("valid_ain", 64'(va_data[i]), 64'(8'(v.aval)));
            end
            if (tight) begin
                check("we_contiguous", 64'(we_cyc[v.n-1] - we_cyc[0]), 64'(v.n - 1));
                check("clear_after_we", 64'(clr_cyc - we_cyc[v.n-1]), 64'd1);
                check("valid_after_clear", 64'(va_cyc[0] - clr_cyc), 64'd1);
                check("valid_contiguous", 64'(va_cyc[v.n-1] - va_cyc[0]), 64'(v.n - 1));
            end else begin
                check("clear_order", 64'((clr_cyc > we_cyc[v.n-1]) && (va_cyc[0] > clr_cyc)),
                      64'd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //           n  sub gap poke base step aval hold  expected
        vecs[0] = '{16, 0, 0, 0, 1, 1, 1, 0,  48'd136};
        vecs[1] = '{16, 1, 0, 0, 1, 1, 1, 0,  48'hFFFF_FFFF_FF78};  // -136
        vecs[2] = '{4,  0, 1, 0, 1, 1, 1, 0,  48'd10};
        vecs[3] = '{4,  0, 0, 0, 1, 1, 1, 10, 48'd10};
        vecs[4] = '{1,  0, 0, 1, 7, 0, 5, 0,  48'd35};
        vecs[5] = '{8,  0, 0, 0, 3, 2, 2, 3,  48'd160};
        vecs[6] = '{8,  1, 1, 0, 3, 2, 2, 0,  48'hFFFF_FFFF_FF60};  // -160

        areset = 1'b1; start = 1'b0; len_m1 = '0; sub = 1'b0;
        d_data = '0; d_valid = 1'b0; a_data = '0; a_valid = 1'b0; res_ready = 1'b0;
        cur_sub = 1'b0;
        clear_mon();
        @(negedge aclk);
        check("reset_outputs", 64'(outs_vec()), 64'd0);
        check("reset_res_data", 64'(res_data), 64'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("idle_outputs", 64'(outs_vec()), 64'd0);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Reset after 3 of 8 activation beats, then a clean N=8 run.
        @(negedge aclk);
        clear_mon();
        cur_sub = 1'b0; start = 1'b1; len_m1 = 4'd7; sub = 1'b0;
        stream(1'b0, 8, 1'b0, 1'b0, 3, 2, 2);
        stream(1'b1, 3, 1'b0, 1'b0, 3, 2, 2);
        @(negedge aclk);
        d_valid = 1'b0; a_valid = 1'b0;
        check("pre_reset_busy", 64'(busy), 64'd1);
        areset = 1'b1;
        #1;
        check("async_reset_outputs", 64'(outs_vec()), 64'd0);
        check("async_reset_res_data", 64'(res_data), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("post_reset_idle", 64'(outs_vec()), 64'd0);
        run_op(vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
